// File: rtl/branch_commit_queue_if.sv
// branch_commit_queue_if: decode/branch-unit/commit bus of the branch commit queue.
// Stat outputs exist only when BR_STATS_EN is defined.
interface branch_commit_queue_if #(parameter int DEPTH = 8);
    localparam int IW = $clog2(DEPTH);
    logic          alloc_valid;
    logic [31:0]   alloc_pc;
    logic          alloc_pred_taken;
    logic [31:0]   alloc_pred_addr;
    logic          alloc_ready;
    logic [IW-1:0] alloc_idx;
    logic          res_valid;
    logic [IW-1:0] res_idx;
    logic          res_taken;
    logic [31:0]   res_target;
    logic          commit_ready;
    logic          pc_result_load;
    logic [31:0]   pc_result;
    logic          br_result;
    logic          flush;
    logic [31:0]   flush_pc;
    logic [IW:0]   count;
`ifdef BR_STATS_EN
    logic [31:0]   stat_commits;
    logic [31:0]   stat_mispredicts;
`endif
    modport master (
        output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_addr,
        output res_valid, res_idx, res_taken, res_target, commit_ready,
        input alloc_ready, alloc_idx, pc_result_load, pc_result, br_result,
        input flush, flush_pc, count
`ifdef BR_STATS_EN
        , input stat_commits, stat_mispredicts
`endif
    );
    modport slave (
        input alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_addr,
        input res_valid, res_idx, res_taken, res_target, commit_ready,
        output alloc_ready, alloc_idx, pc_result_load, pc_result, br_result,
        output flush, flush_pc, count
`ifdef BR_STATS_EN
        , output stat_commits, stat_mispredicts
`endif
    );
endinterface

// File: rtl/branch_commit_queue.sv
// branch_commit_queue: in-order predicted-branch tracker feeding predictor update and mispredict flush.
// Optional BR_STATS_EN adds saturating commit/mispredict counters.
module branch_commit_queue #(
    parameter int DEPTH = 8
) (
    input logic clk,
    input logic rst,
    branch_commit_queue_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    logic [DEPTH-1:0] valid, resolved, pred_taken, act_taken;
    logic [31:0]      pc [DEPTH];
    logic [31:0]      pred_addr [DEPTH];
    logic [31:0]      act_target [DEPTH];
    logic [IW-1:0]    head, tail;
    logic [IW:0]      cnt;
    logic             alloc_fire, res_fire, commit_fire, mispredict;
    logic             load_q, br_q, flush_q;
    logic [31:0]      pc_q, flush_pc_q;
    always_comb begin
        bus.alloc_ready = cnt < (IW+1)'(DEPTH);
        alloc_fire = bus.alloc_valid && bus.alloc_ready;
        res_fire = bus.res_valid && valid[bus.res_idx] && !resolved[bus.res_idx];
        commit_fire = bus.commit_ready && valid[head] && resolved[head];
        mispredict = commit_fire && ((act_target[head] != pred_addr[head]) || (act_taken[head] != pred_taken[head]));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            resolved <= '0;
            head <= '0;
            tail <= '0;
            cnt <= '0;
        end else if (mispredict) begin
            valid <= '0;
            resolved <= '0;
            head <= '0;
            tail <= '0;
            cnt <= '0;
        end else begin
            // commit and alloc never share a slot: a full queue blocks alloc
            if (commit_fire) begin
                valid[head] <= 1'b0;
                resolved[head] <= 1'b0;
                head <= head + 1'b1;
            end
            if (alloc_fire) begin
                valid[tail] <= 1'b1;
                resolved[tail] <= 1'b0;
                pc[tail] <= bus.alloc_pc;
                pred_taken[tail] <= bus.alloc_pred_taken;
                pred_addr[tail] <= bus.alloc_pred_addr;
                tail <= tail + 1'b1;
            end
            if (res_fire) begin
                resolved[bus.res_idx] <= 1'b1;
                act_taken[bus.res_idx] <= bus.res_taken;
                act_target[bus.res_idx] <= bus.res_target;
            end
            cnt <= cnt + (IW+1)'(alloc_fire) - (IW+1)'(commit_fire);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            load_q <= 1'b0;
            br_q <= 1'b0;
            flush_q <= 1'b0;
            pc_q <= '0;
            flush_pc_q <= '0;
        end else begin
            load_q <= commit_fire;
            flush_q <= mispredict;
            if (commit_fire) begin
                pc_q <= pc[head];
                br_q <= act_taken[head];
            end
            if (mispredict) flush_pc_q <= act_target[head];
        end
    end
    assign bus.alloc_idx = tail;
    assign bus.count = cnt;
    assign bus.pc_result_load = load_q;
    assign bus.pc_result = pc_q;
    assign bus.br_result = br_q;
    assign bus.flush = flush_q;
    assign bus.flush_pc = flush_pc_q;
`ifdef BR_STATS_EN
    logic [31:0] stat_c, stat_m;
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_c <= '0;
            stat_m <= '0;
        end else begin
            if (commit_fire && stat_c != '1) stat_c <= stat_c + 1'b1;
            if (mispredict && stat_m != '1) stat_m <= stat_m + 1'b1;
        end
    end
    assign bus.stat_commits = stat_c;
    assign bus.stat_mispredicts = stat_m;
`endif
endmodule
